// File: rtl/l1_dtlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : l1_dtlb_assoc
//  Description : Fully associative L1 data TLB for the E stage. Each entry
//                holds an even/odd page pair (VPN2 granularity) tagged with
//                ASID/G. kseg0/kseg1 are direct-mapped. Misses are refilled
//                from the shared L2 TLB over a req/resp handshake with
//                variable latency. Replacement picks the lowest invalid
//                entry, otherwise a round-robin pointer.
//  Ports       : clk, rst (async, active high)
//                E_mem_en/E_mem_va        -> E_mem_pa/uncached/writeable
//                E_tlb_refill/E_tlb_invalid  registered exception flags
//                E_ready_go, E_dtlb_stall    pipeline handshake
//                cur_asid, fence_tlb         context / flush
//                l2_req/l2_vpn2 -> l2_resp/l2_found/l2_entry  refill port
//                l2_entry layout (MSB..LSB):
//                  {ASID, G, PFN0[19:0], C0, D0, V0, PFN1[19:0], C1, D1, V1}
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_dtlb_assoc #(
    parameter int NR_ENTRY = 4,
    parameter int ASID_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E_mem_en,
    input  logic [31:0]       E_mem_va,
    output logic [31:0]       E_mem_pa,
    output logic              E_mem_uncached,
    output logic              E_mem_writeable,
    output logic              E_tlb_refill,
    output logic              E_tlb_invalid,
    input  logic              E_ready_go,
    output logic              E_dtlb_stall,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              fence_tlb,
    output logic              l2_req,
    output logic [18:0]       l2_vpn2,
    input  logic              l2_resp,
    input  logic              l2_found,
    input  logic [ASID_W+46:0] l2_entry
);

    localparam int ENTRY_W = ASID_W + 47;
    localparam int IDX_W   = (NR_ENTRY > 1) ? $clog2(NR_ENTRY) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_EXC    = 2'd2;

    // ------------------------------------------------------------------
    // Entry storage: valid bits are reset, payload is not.
    // ------------------------------------------------------------------
    logic [NR_ENTRY-1:0] valid_q, valid_d;
    logic [18:0]         vpn2_q [NR_ENTRY];
    logic [ASID_W-1:0]   asid_q [NR_ENTRY];
    logic [19:0]         pfn0_q [NR_ENTRY];
    logic [19:0]         pfn1_q [NR_ENTRY];
    logic [NR_ENTRY-1:0] g_q;
    logic [NR_ENTRY-1:0] c0_q, d0_q, v0_q;
    logic [NR_ENTRY-1:0] c1_q, d1_q, v1_q;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rr_q;
    logic             refill_q, invalid_q, req_q;
    logic [18:0]      vpn2_req_q;
    logic             half_q;       // va[12] of the in-flight miss
    logic             fence_pend_q; // fence seen while waiting on L2

    // ------------------------------------------------------------------
    // L2 response fields
    // ------------------------------------------------------------------
    logic [ASID_W-1:0] w_l2_asid;
    logic              w_l2_g;
    logic [19:0]       w_l2_pfn0, w_l2_pfn1;
    logic              w_l2_c0, w_l2_d0, w_l2_v0;
    logic              w_l2_c1, w_l2_d1, w_l2_v1;
    logic              w_l2_vhalf;

    assign w_l2_asid  = l2_entry[ENTRY_W-1 -: ASID_W];
    assign w_l2_g     = l2_entry[46];
    assign w_l2_pfn0  = l2_entry[45:26];
    assign w_l2_c0    = l2_entry[25];
    assign w_l2_d0    = l2_entry[24];
    assign w_l2_v0    = l2_entry[23];
    assign w_l2_pfn1  = l2_entry[22:3];
    assign w_l2_c1    = l2_entry[2];
    assign w_l2_d1    = l2_entry[1];
    assign w_l2_v1    = l2_entry[0];
    assign w_l2_vhalf = half_q ? w_l2_v1 : w_l2_v0;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic                w_direct;
    logic [NR_ENTRY-1:0] w_match;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_half;
    logic                w_vhalf;

    assign w_direct = (E_mem_va[31:30] == 2'b10);
    assign w_half   = E_mem_va[12];

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NR_ENTRY; i++) begin
            w_match[i] = valid_q[i] && (vpn2_q[i] == E_mem_va[31:13]) &&
                         (g_q[i] || (asid_q[i] == cur_asid));
        end
    end

    // Descending scan so the lowest matching index is the final winner;
    // with no match the index stays 0, which drives the don't-care data.
    always_comb begin
        w_hit_idx = '0;
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_idx = IDX_W'(i);
        end
    end

    assign w_hit   = |w_match;
    assign w_vhalf = w_half ? v1_q[w_hit_idx] : v0_q[w_hit_idx];

    // ------------------------------------------------------------------
    // Victim selection and refill write
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_victim;
    logic             w_use_rr;
    logic             w_fence;
    logic             w_resp;
    logic             w_write;

    always_comb begin
        w_victim = rr_q;
        w_use_rr = 1'b1;
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_victim = IDX_W'(i);
                w_use_rr = 1'b0;
            end
        end
    end

    assign w_fence = fence_tlb & E_ready_go;
    assign w_resp  = (state_q == S_REFILL) & l2_resp;
    // A fence anywhere during the refill window discards the response.
    assign w_write = w_resp & l2_found & ~w_fence & ~fence_pend_q;

    always_comb begin
        valid_d = valid_q;
        if (w_fence) begin
            valid_d = '0;
        end else if (w_write) begin
            valid_d[w_victim] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            vpn2_q[w_victim] <= vpn2_req_q;
            asid_q[w_victim] <= w_l2_asid;
            g_q[w_victim]    <= w_l2_g;
            pfn0_q[w_victim] <= w_l2_pfn0;
            c0_q[w_victim]   <= w_l2_c0;
            d0_q[w_victim]   <= w_l2_d0;
            v0_q[w_victim]   <= w_l2_v0;
            pfn1_q[w_victim] <= w_l2_pfn1;
            c1_q[w_victim]   <= w_l2_c1;
            d1_q[w_victim]   <= w_l2_d1;
            v1_q[w_victim]   <= w_l2_v1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (w_write && w_use_rr) begin
                if (rr_q == IDX_W'(NR_ENTRY - 1)) rr_q <= '0;
                else                              rr_q <= rr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (E_mem_en && !w_direct) begin
                    if (!w_hit)        state_d = S_REFILL;
                    else if (!w_vhalf) state_d = S_EXC;
                end
            end
            S_REFILL: begin
                if (l2_resp) begin
                    // An access that went away no longer needs an exception.
                    if (!E_mem_en)        state_d = S_IDLE;
                    else if (!l2_found)   state_d = S_EXC;
                    else if (w_l2_vhalf)  state_d = S_IDLE;
                    else                  state_d = S_EXC;
                end
            end
            S_EXC: begin
                if (E_ready_go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and refill bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_q     <= 1'b0;
            invalid_q    <= 1'b0;
            req_q        <= 1'b0;
            vpn2_req_q   <= '0;
            half_q       <= 1'b0;
            fence_pend_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (E_mem_en && !w_direct) begin
                        if (!w_hit) begin
                            req_q        <= 1'b1;
                            vpn2_req_q   <= E_mem_va[31:13];
                            half_q       <= E_mem_va[12];
                            fence_pend_q <= 1'b0;
                        end else if (!w_vhalf) begin
                            invalid_q <= 1'b1;
                        end
                    end
                end
                S_REFILL: begin
                    if (l2_resp) begin
                        req_q        <= 1'b0;
                        fence_pend_q <= 1'b0;
                        if (E_mem_en) begin
                            if (!l2_found)        refill_q  <= 1'b1;
                            else if (!w_l2_vhalf) invalid_q <= 1'b1;
                        end
                    end else if (w_fence) begin
                        fence_pend_q <= 1'b1;
                    end
                end
                S_EXC: begin
                    if (E_ready_go) begin
                        refill_q  <= 1'b0;
                        invalid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        if (w_direct) begin
            E_mem_pa        = {3'b000, E_mem_va[28:0]};
            E_mem_uncached  = E_mem_va[29];
            E_mem_writeable = 1'b1;
        end else if (w_half) begin
            E_mem_pa        = {pfn1_q[w_hit_idx], E_mem_va[11:0]};
            E_mem_uncached  = ~c1_q[w_hit_idx];
            E_mem_writeable = d1_q[w_hit_idx];
        end else begin
            E_mem_pa        = {pfn0_q[w_hit_idx], E_mem_va[11:0]};
            E_mem_uncached  = ~c0_q[w_hit_idx];
            E_mem_writeable = d0_q[w_hit_idx];
        end
        E_dtlb_stall = E_mem_en &
                       ~((state_q == S_EXC) |
                         ((state_q == S_IDLE) & (w_direct | (w_hit & w_vhalf))));
    end

    assign E_tlb_refill  = refill_q;
    assign E_tlb_invalid = invalid_q;
    assign l2_req        = req_q;
    assign l2_vpn2       = vpn2_req_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_dtlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_dtlb_assoc
//  Description : Self-checking bench for l1_dtlb_assoc: a table of lookup
//                vectors plus hand-written refill / exception / fence /
//                reset sequences with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_l1_dtlb_assoc;

    localparam int NR_ENTRY = 4;
    localparam int ASID_W   = 8;
    localparam int EW       = ASID_W + 47;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              E_mem_en;
    logic [31:0]       E_mem_va;
    logic [31:0]       E_mem_pa;
    logic              E_mem_uncached;
    logic              E_mem_writeable;
    logic              E_tlb_refill;
    logic              E_tlb_invalid;
    logic              E_ready_go;
    logic              E_dtlb_stall;
    logic [ASID_W-1:0] cur_asid;
    logic              fence_tlb;
    logic              l2_req;
    logic [18:0]       l2_vpn2;
    logic              l2_resp;
    logic              l2_found;
    logic [EW-1:0]     l2_entry;

    always #5 clk = ~clk;

    l1_dtlb_assoc #(.NR_ENTRY(NR_ENTRY), .ASID_W(ASID_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .E_mem_en        (E_mem_en),
        .E_mem_va        (E_mem_va),
        .E_mem_pa        (E_mem_pa),
        .E_mem_uncached  (E_mem_uncached),
        .E_mem_writeable (E_mem_writeable),
        .E_tlb_refill    (E_tlb_refill),
        .E_tlb_invalid   (E_tlb_invalid),
        .E_ready_go      (E_ready_go),
        .E_dtlb_stall    (E_dtlb_stall),
        .cur_asid        (cur_asid),
        .fence_tlb       (fence_tlb),
        .l2_req          (l2_req),
        .l2_vpn2         (l2_vpn2),
        .l2_resp         (l2_resp),
        .l2_found        (l2_found),
        .l2_entry        (l2_entry)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] pa;
        logic        uc;
        logic        wr;
        logic        stall;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk_entry(
        input logic [ASID_W-1:0] asid, input logic g,
        input logic [19:0] pfn0, input logic c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic c1, input logic d1, input logic v1);
        return {asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    // Lookups are applied mid-cycle and E_mem_en is dropped before the edge,
    // so a missing vector does not launch a refill.
    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            E_mem_en = 1'b1;
            E_mem_va = vt[i].va;
            #2;
            chk($sformatf("v%0d_stall", i), E_dtlb_stall, vt[i].stall);
            if (!vt[i].stall) begin
                chk($sformatf("v%0d_pa", i), E_mem_pa, vt[i].pa);
                chk($sformatf("v%0d_uc", i), E_mem_uncached, vt[i].uc);
                chk($sformatf("v%0d_wr", i), E_mem_writeable, vt[i].wr);
            end
            chk($sformatf("v%0d_noreq", i), l2_req, 1'b0);
            E_mem_en = 1'b0;
            tick();
        end
    endtask

    // Miss at va, L2 answers after lat extra REFILL cycles.
    task automatic do_miss(input logic [31:0] va, input int lat,
                           input logic found, input logic [EW-1:0] ent);
        logic [18:0] vpn;
        vpn = va[31:13];
        E_mem_en = 1'b1;
        E_mem_va = va;
        #1;
        chk("miss_stall", E_dtlb_stall, 1'b1);
        tick();
        chk("req_up", l2_req, 1'b1);
        chk("req_vpn2", l2_vpn2, vpn);
        for (int k = 0; k < lat; k++) begin
            #1;
            chk("refill_stall", E_dtlb_stall, 1'b1);
            tick();
            chk("req_held", l2_req, 1'b1);
            chk("vpn2_stable", l2_vpn2, vpn);
        end
        l2_resp  = 1'b1;
        l2_found = found;
        l2_entry = ent;
        tick();
        l2_resp  = 1'b0;
        l2_found = 1'b0;
        chk("req_drop", l2_req, 1'b0);
    endtask

    initial begin
        E_mem_en   = 1'b0;
        E_mem_va   = '0;
        E_ready_go = 1'b0;
        cur_asid   = 8'd1;
        fence_tlb  = 1'b0;
        l2_resp    = 1'b0;
        l2_found   = 1'b0;
        l2_entry   = '0;

        // Direct-mapped segment
        vt[0]  = '{32'h8000_1234, 32'h0000_1234, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{32'hA000_0010, 32'h0000_0010, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{32'h9FFF_FFFF, 32'h1FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{32'hBFFF_FFFC, 32'h1FFF_FFFC, 1'b1, 1'b1, 1'b0};
        // After filling k=0..4 (k=4 evicts k=0)
        vt[4]  = '{32'h0100_0044, 32'h0,         1'b0, 1'b0, 1'b1};
        vt[5]  = '{32'h0100_2044, 32'h0010_1044, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{32'h0100_5044, 32'h0020_2044, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{32'h0100_6044, 32'h0010_3044, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{32'h0100_9044, 32'h0020_4044, 1'b1, 1'b0, 1'b0};
        // After filling k=5 (rr now evicts entry 1 = k=1)
        vt[9]  = '{32'h0100_2044, 32'h0,         1'b0, 1'b0, 1'b1};
        vt[10] = '{32'h0100_A044, 32'h0010_5044, 1'b0, 1'b1, 1'b0};
        vt[11] = '{32'h0100_5044, 32'h0020_2044, 1'b1, 1'b0, 1'b0};
        vt[12] = '{32'h0100_8044, 32'h0010_4044, 1'b0, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("rst_req", l2_req, 1'b0);
        chk("rst_vpn2", l2_vpn2, 19'h0);
        chk("rst_refill", E_tlb_refill, 1'b0);
        chk("rst_invalid", E_tlb_invalid, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Direct map
        apply_vecs(0, 3);

        // 2. Refill hit on odd page, then V0=0 half raises invalid
        do_miss(32'h0040_3008, 2, 1'b1,
                mk_entry(8'd1, 1'b0, 20'h0ABCD, 1'b1, 1'b0, 1'b0,
                         20'h12345, 1'b1, 1'b1, 1'b1));
        #1;
        chk("t2_pa", E_mem_pa, 32'h1234_5008);
        chk("t2_uc", E_mem_uncached, 1'b0);
        chk("t2_wr", E_mem_writeable, 1'b1);
        chk("t2_stall", E_dtlb_stall, 1'b0);
        chk("t2_noexc", {E_tlb_refill, E_tlb_invalid}, 2'b00);
        E_mem_va = 32'h0040_2000;
        #1;
        chk("t2_inv_stall", E_dtlb_stall, 1'b1);
        tick();
        chk("t2_invalid", E_tlb_invalid, 1'b1);
        chk("t2_inv_noreq", l2_req, 1'b0);
        chk("t2_exc_nostall", E_dtlb_stall, 1'b0);
        E_ready_go = 1'b1;
        tick();
        E_ready_go = 1'b0;
        E_mem_en   = 1'b0;
        chk("t2_inv_clr", E_tlb_invalid, 1'b0);
        tick();

        // 3. L2 miss -> refill exception held until E_ready_go
        do_miss(32'h0060_0000, 1, 1'b0, '0);
        chk("t3_refill", E_tlb_refill, 1'b1);
        chk("t3_exc_nostall", E_dtlb_stall, 1'b0);
        tick();
        chk("t3_refill_held", E_tlb_refill, 1'b1);
        E_ready_go = 1'b1;
        tick();
        E_ready_go = 1'b0;
        E_mem_en   = 1'b0;
        chk("t3_refill_clr", E_tlb_refill, 1'b0);
        chk("t3_noreq", l2_req, 1'b0);

        // 4. Fill five VPN2s into four entries, then a sixth
        fence_tlb  = 1'b1;
        E_ready_go = 1'b1;
        tick();
        fence_tlb  = 1'b0;
        E_ready_go = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_miss(32'h0100_0000 + k * 32'h2000, k % 3, 1'b1,
                    mk_entry(8'd0, 1'b1, 20'h00100 + 20'(k), 1'b1, 1'b1, 1'b1,
                             20'h00200 + 20'(k), 1'b0, 1'b0, 1'b1));
            E_mem_en = 1'b0;
            tick();
            if (k == 4) apply_vecs(4, 8);
        end
        apply_vecs(9, 12);

        // 5. ASID tagging and global pages
        cur_asid = 8'd5;
        do_miss(32'h0200_0000, 0, 1'b1,
                mk_entry(8'd5, 1'b0, 20'h0AAAA, 1'b1, 1'b1, 1'b1,
                         20'h0AAAB, 1'b1, 1'b1, 1'b1));
        E_mem_en = 1'b0;
        tick();
        do_miss(32'h0300_0000, 0, 1'b1,
                mk_entry(8'd5, 1'b1, 20'h0BBBB, 1'b1, 1'b1, 1'b1,
                         20'h0BBBC, 1'b1, 1'b1, 1'b1));
        E_mem_en = 1'b0;
        tick();
        cur_asid = 8'd6;
        E_mem_en = 1'b1;
        E_mem_va = 32'h0200_0123;
        #1;
        chk("t5_asid_miss", E_dtlb_stall, 1'b1);
        E_mem_va = 32'h0300_0456;
        #1;
        chk("t5_g_hit", E_dtlb_stall, 1'b0);
        chk("t5_g_pa", E_mem_pa, 32'h0BBB_B456);
        E_mem_en = 1'b0;
        tick();
        do_miss(32'h0200_0000, 2, 1'b1,
                mk_entry(8'd6, 1'b0, 20'h0DDDD, 1'b1, 1'b1, 1'b1,
                         20'h0DDDE, 1'b1, 1'b1, 1'b1));
        E_mem_va = 32'h0200_0123;
        #1;
        chk("t5_new_hit", E_dtlb_stall, 1'b0);
        chk("t5_new_pa", E_mem_pa, 32'h0DDD_D123);
        E_mem_en = 1'b0;
        tick();

        // 6. Fence during REFILL, fence on the response cycle, async reset
        E_mem_en = 1'b1;
        E_mem_va = 32'h0400_0000;
        tick();
        chk("t6_req", l2_req, 1'b1);
        fence_tlb  = 1'b1;
        E_ready_go = 1'b1;
        tick();
        fence_tlb  = 1'b0;
        E_ready_go = 1'b0;
        chk("t6_req_held", l2_req, 1'b1);
        l2_resp  = 1'b1;
        l2_found = 1'b1;
        l2_entry = mk_entry(8'd6, 1'b0, 20'h0CCCC, 1'b1, 1'b1, 1'b1,
                            20'h0CCCD, 1'b1, 1'b1, 1'b1);
        tick();
        l2_resp  = 1'b0;
        l2_found = 1'b0;
        chk("t6_req_drop", l2_req, 1'b0);
        #1;
        chk("t6_not_written", E_dtlb_stall, 1'b1);
        E_mem_va = 32'h0300_0456;
        #1;
        chk("t6_fenced_g", E_dtlb_stall, 1'b1);
        tick();
        chk("t6_remiss_req", l2_req, 1'b1);
        chk("t6_remiss_vpn2", l2_vpn2, 19'h01800);
        l2_resp    = 1'b1;
        l2_found   = 1'b1;
        fence_tlb  = 1'b1;
        E_ready_go = 1'b1;
        l2_entry   = mk_entry(8'd5, 1'b1, 20'h0BBBB, 1'b1, 1'b1, 1'b1,
                              20'h0BBBC, 1'b1, 1'b1, 1'b1);
        tick();
        l2_resp    = 1'b0;
        l2_found   = 1'b0;
        fence_tlb  = 1'b0;
        E_ready_go = 1'b0;
        chk("t6_req_drop2", l2_req, 1'b0);
        #1;
        chk("t6_fence_wins", E_dtlb_stall, 1'b1);
        tick();
        chk("t6_req_again", l2_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_req", l2_req, 1'b0);
        chk("t6_async_vpn2", l2_vpn2, 19'h0);
        chk("t6_async_refill", E_tlb_refill, 1'b0);
        E_mem_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        E_mem_en = 1'b1;
        E_mem_va = 32'h8000_0040;
        #1;
        chk("t6_post_pa", E_mem_pa, 32'h0000_0040);
        chk("t6_post_stall", E_dtlb_stall, 1'b0);
        E_mem_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
